// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, column constants and frame classifier for the keypad scanner
package keypad_pkg;

    typedef logic [3:0] key_code_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_EMIT    = 2'd2,
        ST_HOLD    = 2'd3
    } scan_state_t;

    typedef enum logic [1:0] {
        FR_NONE   = 2'd0,
        FR_SINGLE = 2'd1,
        FR_MULTI  = 2'd2
    } frame_kind_t;

    typedef struct packed {
        frame_kind_t kind;
        key_code_t   code;
    } frame_class_t;

    localparam logic [3:0] COL0 = 4'b1000;
    localparam logic [3:0] COL1 = 4'b0100;
    localparam logic [3:0] COL2 = 4'b0010;
    localparam logic [3:0] COL3 = 4'b0001;

    // Frame bit index is row*4 + column, so a lone set bit is directly the key code.
    function automatic frame_class_t classify(input logic [15:0] frame);
        frame_class_t res;
        int unsigned  ones;
        res.kind = FR_NONE;
        res.code = '0;
        ones     = 0;
        for (int i = 0; i < 16; i++) begin
            if (frame[i]) begin
                ones++;
                res.code = key_code_t'(i);
            end
        end
        if (ones == 1)
            res.kind = FR_SINGLE;
        else if (ones > 1)
            res.kind = FR_MULTI;
        return res;
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// rtl/keypad_scan_ctrl_if.sv - key code valid/ready handshake bundle with producer and consumer views
interface keypad_scan_ctrl_if;
    import keypad_pkg::*;

    key_code_t key_code;
    logic      key_valid;
    logic      key_ready;
    logic      key_down;

    modport master (output key_code, output key_valid, output key_down, input key_ready);
    modport slave  (input key_code, input key_valid, input key_down, output key_ready);
endinterface

// File: rtl/keypad_col_seq.sv
// rtl/keypad_col_seq.sv - one-hot column sequencer with per-column settle timer and sample strobe
module keypad_col_seq
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES = 27
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] columnas,
    output logic       sample,
    output logic [1:0] col_idx
);

    localparam logic [15:0] LAST_CYCLE = 16'(SETTLE_CYCLES - 1);

    logic [15:0] settle_cnt;

    // Strobe on the final clock of the column period, when rows have settled longest.
    assign sample = (settle_cnt == LAST_CYCLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            settle_cnt <= '0;
            col_idx    <= '0;
        end else if (sample) begin
            settle_cnt <= '0;
            col_idx    <= col_idx + 2'd1;
        end else begin
            settle_cnt <= settle_cnt + 16'd1;
        end
    end

    always_comb begin
        columnas = COL0;
        case (col_idx)
            2'd1:    columnas = COL1;
            2'd2:    columnas = COL2;
            2'd3:    columnas = COL3;
            default: columnas = COL0;
        endcase
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 4x4 keypad scanner: frame capture, debounce FSM, code handshake
// Optional auto-repeat while a key is held is built only when KEYPAD_REPEAT_EN is defined.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int CLK_HZ        = 27_000_000,
    parameter int SETTLE_CYCLES = 27,
    parameter int STABLE_FRAMES = 4,
    parameter int REPEAT_FRAMES = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [3:0]                rows,
    output logic [3:0]                columnas,
    keypad_scan_ctrl_if.master        key
);

    if (CLK_HZ < 1 || SETTLE_CYCLES < 2 || SETTLE_CYCLES > 65535 ||
        STABLE_FRAMES < 1 || STABLE_FRAMES > 15 || REPEAT_FRAMES < 1) begin : g_bad_param
        $error("keypad_scan_ctrl: parameter out of range");
    end

    localparam logic [3:0] STABLE_N = 4'(STABLE_FRAMES);

    logic         sample;
    logic [1:0]   col_idx;
    logic [3:0]   row_bits;
    logic [15:0]  frame_acc;
    logic [15:0]  frame;
    logic         frame_end;
    frame_class_t fc;
    logic         is_single;
    scan_state_t  state;
    key_code_t    cand;
    logic [3:0]   stable_cnt;
    logic [3:0]   cnt_inc;

    keypad_col_seq #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_col_seq (
        .clk      (clk),
        .reset    (reset),
        .columnas (columnas),
        .sample   (sample),
        .col_idx  (col_idx)
    );

    // row_bits[r] is row r; row0 arrives on rows[3].
    assign row_bits = {rows[0], rows[1], rows[2], rows[3]};

    always_comb begin
        frame = frame_acc;
        for (int r = 0; r < 4; r++)
            frame[r*4 + int'(col_idx)] = row_bits[r];
    end

    assign frame_end = sample && (col_idx == 2'd3);
    assign fc        = classify(frame);
    assign is_single = (fc.kind == FR_SINGLE);
    assign cnt_inc   = (stable_cnt == 4'hF) ? stable_cnt : stable_cnt + 4'd1;
    assign key.key_down = (state == ST_EMIT) || (state == ST_HOLD);

`ifdef KEYPAD_REPEAT_EN
    localparam logic [15:0] REPEAT_N = 16'(REPEAT_FRAMES);
    logic [15:0] rep_cnt;
    logic [15:0] rep_inc;
    assign rep_inc = (rep_cnt == 16'hFFFF) ? rep_cnt : rep_cnt + 16'd1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            cand          <= '0;
            stable_cnt    <= '0;
            frame_acc     <= '0;
            key.key_code  <= '0;
            key.key_valid <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt       <= '0;
`endif
        end else begin
            if (sample)
                frame_acc <= frame;
            case (state)
                ST_IDLE: begin
                    if (frame_end && is_single) begin
                        cand <= fc.code;
                        if (STABLE_N == 4'd1) begin
                            state         <= ST_EMIT;
                            stable_cnt    <= '0;
                            key.key_code  <= fc.code;
                            key.key_valid <= 1'b1;
                        end else begin
                            state      <= ST_CONFIRM;
                            stable_cnt <= 4'd1;
                        end
                    end
                end
                ST_CONFIRM: begin
                    if (frame_end) begin
                        if (!is_single) begin
                            state      <= ST_IDLE;
                            stable_cnt <= '0;
                        end else if (fc.code != cand) begin
                            cand       <= fc.code;
                            stable_cnt <= 4'd1;
                        end else if (cnt_inc >= STABLE_N) begin
                            state         <= ST_EMIT;
                            stable_cnt    <= '0;
                            key.key_code  <= cand;
                            key.key_valid <= 1'b1;
                        end else begin
                            stable_cnt <= cnt_inc;
                        end
                    end
                end
                // Frames are ignored here; release is only tracked once the code is delivered.
                ST_EMIT: begin
                    if (key.key_valid && key.key_ready) begin
                        key.key_valid <= 1'b0;
                        state         <= ST_HOLD;
                        stable_cnt    <= '0;
`ifdef KEYPAD_REPEAT_EN
                        rep_cnt       <= '0;
`endif
                    end
                end
                ST_HOLD: begin
                    if (frame_end) begin
                        if (is_single && fc.code == key.key_code) begin
                            stable_cnt <= '0;
`ifdef KEYPAD_REPEAT_EN
                            if (!key.key_valid && rep_inc >= REPEAT_N) begin
                                state         <= ST_EMIT;
                                key.key_valid <= 1'b1;
                                rep_cnt       <= '0;
                            end else begin
                                rep_cnt <= rep_inc;
                            end
`endif
                        end else begin
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt <= '0;
`endif
                            if (cnt_inc >= STABLE_N) begin
                                state      <= ST_IDLE;
                                stable_cnt <= '0;
                            end else begin
                                stable_cnt <= cnt_inc;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - directed scoreboard bench for keypad_scan_ctrl (KEYPAD_REPEAT_EN aware)
module tb_keypad_scan_ctrl;
    import keypad_pkg::*;

    localparam int SETTLE = 27;
    localparam int FRAME  = 4 * SETTLE;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  rows;
    logic [3:0]  columnas;
    logic [15:0] keys  = '0;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    key_code_t exp_q[$];

    keypad_scan_ctrl_if kif ();

    keypad_scan_ctrl #(
        .CLK_HZ        (27_000_000),
        .SETTLE_CYCLES (SETTLE),
        .STABLE_FRAMES (4),
        .REPEAT_FRAMES (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rows     (rows),
        .columnas (columnas),
        .key      (kif)
    );

    always #5 clk = ~clk;

    // Keypad matrix: key (r,c) connects column c drive to row r.
    always_comb begin
        rows = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (columnas[3-c] && keys[r*4+c])
                    rows[3-r] = 1'b1;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_clks(input int n);
        repeat (n) step();
    endtask

    task automatic sync_frame();
        logic [3:0] prev;
        logic       got;
        got  = 1'b0;
        prev = columnas;
        for (int i = 0; i < 2*FRAME && !got; i++) begin
            step();
            if (prev == 4'b0001 && columnas == 4'b1000)
                got = 1'b1;
            prev = columnas;
        end
        chk("frame_sync", 16'(got), 16'd1);
    endtask

    always @(negedge clk) begin
        if (!reset && kif.key_valid && kif.key_ready) begin
            pulses++;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_code: observed=%0d expected=none", kif.key_code);
            end
            if (exp_q.size() != 0) begin
                key_code_t e;
                e = exp_q.pop_front();
                checks++;
                assert (kif.key_code === e) else begin
                    errors++;
                    $error("FAIL sb_code: observed=%0d expected=%0d", kif.key_code, e);
                end
            end
        end
    end

    initial begin
        int         p0;
        logic [3:0] ec;
        kif.key_ready = 1'b1;

        // Reset state
        reset = 1'b1;
        wait_clks(3);
        chk("rst_columnas", 16'(columnas), 16'h8);
        chk("rst_valid", 16'(kif.key_valid), 16'd0);
        chk("rst_code", 16'(kif.key_code), 16'd0);
        chk("rst_down", 16'(kif.key_down), 16'd0);

        // Idle scanning for 3 frames, 27 clocks per column
        reset = 1'b0;
        for (int n = 0; n < 3*FRAME; n++) begin
            ec = 4'b1000 >> ((n / SETTLE) % 4);
            chk("idle_col", 16'(columnas), 16'(ec));
            if (n % SETTLE == 0)
                chk("idle_valid", 16'(kif.key_valid), 16'd0);
            step();
        end

        // Row1/column2 -> code 6, immediate handshake, release after 4 frames
        keys = '0;
        keys[6] = 1'b1;
        exp_q.push_back(4'd6);
        p0 = pulses;
        wait_clks(4*FRAME - 1);
        chk("k6_not_yet", 16'(kif.key_valid), 16'd0);
        step();
        chk("k6_valid", 16'(kif.key_valid), 16'd1);
        chk("k6_code", 16'(kif.key_code), 16'd6);
        chk("k6_down", 16'(kif.key_down), 16'd1);
        step();
        chk("k6_valid_fall", 16'(kif.key_valid), 16'd0);
        chk("k6_down_hold", 16'(kif.key_down), 16'd1);
        keys = '0;
        wait_clks(3*FRAME - 1);
        chk("k6_down_3f", 16'(kif.key_down), 16'd1);
        wait_clks(FRAME);
        chk("k6_down_4f", 16'(kif.key_down), 16'd0);
        chk("k6_pulses", 16'(pulses - p0), 16'd1);

        // Row0/column0 -> code 0 held unacknowledged for 500 clocks
        kif.key_ready = 1'b0;
        keys[0] = 1'b1;
        exp_q.push_back(4'd0);
        wait_clks(4*FRAME);
        for (int i = 0; i < 500; i++) begin
            if (i % 50 == 0) begin
                chk("k0_valid_held", 16'(kif.key_valid), 16'd1);
                chk("k0_code_held", 16'(kif.key_code), 16'd0);
            end
            step();
        end
        kif.key_ready = 1'b1;
        chk("k0_valid_pre_hs", 16'(kif.key_valid), 16'd1);
        step();
        chk("k0_valid_post_hs", 16'(kif.key_valid), 16'd0);
        chk("k0_down_post_hs", 16'(kif.key_down), 16'd1);
        keys = '0;
        wait_clks(5*FRAME);
        chk("k0_released", 16'(kif.key_down), 16'd0);
        sync_frame();

        // Rows 0 and 2 on column1 -> MULTI, then row0 alone -> code 1
        keys[1] = 1'b1;
        keys[9] = 1'b1;
        wait_clks(6*FRAME);
        chk("multi_valid", 16'(kif.key_valid), 16'd0);
        chk("multi_down", 16'(kif.key_down), 16'd0);
        keys[9] = 1'b0;
        exp_q.push_back(4'd1);
        wait_clks(4*FRAME);
        chk("k1_valid", 16'(kif.key_valid), 16'd1);
        chk("k1_code", 16'(kif.key_code), 16'd1);
        keys = '0;
        wait_clks(5*FRAME);
        chk("k1_released", 16'(kif.key_down), 16'd0);
        sync_frame();

        // Reset during CONFIRM discards the candidate; 4 fresh frames needed
        keys[5] = 1'b1;
        wait_clks(3*FRAME);
        chk("k5_confirm_valid", 16'(kif.key_valid), 16'd0);
        reset = 1'b1;
        wait_clks(2);
        chk("k5_rst_valid", 16'(kif.key_valid), 16'd0);
        chk("k5_rst_down", 16'(kif.key_down), 16'd0);
        chk("k5_rst_col", 16'(columnas), 16'h8);
        reset = 1'b0;
        exp_q.push_back(4'd5);
        wait_clks(4*FRAME - 1);
        chk("k5_fresh_not_yet", 16'(kif.key_valid), 16'd0);
        step();
        chk("k5_valid", 16'(kif.key_valid), 16'd1);
        chk("k5_code", 16'(kif.key_code), 16'd5);
        keys = '0;
        wait_clks(5*FRAME);
        chk("k5_released", 16'(kif.key_down), 16'd0);
        sync_frame();

        // Row3/column3 held for 24 frames -> code 15 (repeating every 8 frames if enabled)
        keys[15] = 1'b1;
        p0 = pulses;
        exp_q.push_back(4'd15);
`ifdef KEYPAD_REPEAT_EN
        exp_q.push_back(4'd15);
        exp_q.push_back(4'd15);
`endif
        wait_clks(4*FRAME);
        chk("k15_valid", 16'(kif.key_valid), 16'd1);
        chk("k15_code", 16'(kif.key_code), 16'd15);
        wait_clks(20*FRAME);
`ifdef KEYPAD_REPEAT_EN
        chk("k15_pulses", 16'(pulses - p0), 16'd3);
`else
        chk("k15_pulses", 16'(pulses - p0), 16'd1);
`endif
        keys = '0;
        wait_clks(5*FRAME);
        chk("k15_released", 16'(kif.key_down), 16'd0);
        chk("sb_empty", 16'(exp_q.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 27_000_000, input clock frequency in Hz.
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 27, clocks each column is driven before rows are sampled; legal range 2..65535.
REQ-003 The block SHALL have parameter STABLE_FRAMES, default 4, consecutive identical scan frames required to accept a key; legal range 1..15.
REQ-004 The block SHALL have parameter REPEAT_FRAMES, default 64, frames between auto-repeat codes; used only when KEYPAD_REPEAT_EN is defined.
REQ-005 The block SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port rows, input, 4 bits: debounced row levels, 1 = pressed; row0 = rows[3].
REQ-008 The block SHALL have port columnas, output, 4 bits: one-hot column drive; column0 = 4'b1000.
REQ-009 The block SHALL have port key_code, output, 4 bits: code = row*4 + column.
REQ-010 The block SHALL have port key_valid, output, 1 bit: key_code holds an undelivered code.
REQ-011 The block SHALL have port key_ready, input, 1 bit: consumer accepts the code when key_valid && key_ready.
REQ-012 The block SHALL have port key_down, output, 1 bit: an accepted key is currently held.

Function
REQ-013 Scan order SHALL be 1000 -> 0100 -> 0010 -> 0001 -> 1000, each column driven exactly SETTLE_CYCLES clocks.
REQ-014 rows SHALL be sampled only on the last clock of each column period; the four samples form one 16-bit frame.
REQ-015 A frame SHALL be classed NONE (0 bits set), SINGLE (exactly 1 bit set, giving code), or MULTI (2 or more bits set); MULTI SHALL be treated as NONE.
REQ-016 FSM states SHALL be IDLE, CONFIRM, EMIT and HOLD; scanning SHALL continue in every state.
REQ-017 IDLE -> CONFIRM SHALL occur on a SINGLE frame, latching the candidate code and setting the stable count to 1.
REQ-018 In CONFIRM, a frame with the same code SHALL increment the count; reaching STABLE_FRAMES SHALL go to EMIT; a different code SHALL restart CONFIRM with the new code; NONE SHALL return to IDLE.
REQ-019 With STABLE_FRAMES = 1, a SINGLE frame in IDLE SHALL go directly to EMIT.
REQ-020 On entering EMIT, key_valid SHALL rise on the clock after the deciding frame end; key_code SHALL be stable while key_valid is high.
REQ-021 key_valid SHALL fall on the clock after the key_valid && key_ready handshake; the state SHALL then become HOLD.
REQ-022 If key_ready is already high, the handshake SHALL complete in one cycle.
REQ-023 key_down SHALL be high in EMIT and HOLD and low otherwise.
REQ-024 HOLD -> IDLE SHALL occur after STABLE_FRAMES consecutive frames without the held code; a different single key during HOLD SHALL be ignored.
REQ-025 If the key is released while in EMIT, key_valid SHALL stay high until the handshake; release SHALL then be tracked in HOLD.
REQ-026 The scan-clock counter SHALL wrap to 0 at SETTLE_CYCLES-1; the frame and repeat counters SHALL saturate, never wrap.

Reset
REQ-027 While reset is high at a clock edge: columnas = 4'b1000, key_valid = 0, key_code = 0, key_down = 0, FSM = IDLE, all counters = 0.
REQ-028 Assertion of reset mid-frame or mid-handshake SHALL discard the pending code without emitting it.
REQ-029 The first column period after reset deasserts SHALL be a full SETTLE_CYCLES long.

Configuration
REQ-030 With KEYPAD_REPEAT_EN defined, HOLD SHALL re-enter EMIT with the same code after every REPEAT_FRAMES frames in which the key stays held and key_valid is low.
REQ-031 Without KEYPAD_REPEAT_EN, each press SHALL produce exactly one code, and the repeat counter SHALL not exist in hardware.

Structure
REQ-032 A shared package keypad_pkg SHALL hold the FSM state enum, the column one-hot constants, and the key_code typedef (logic [3:0]).
REQ-033 Column sequencing SHALL be a sub-module keypad_col_seq, outputting columnas and a one-cycle sample strobe plus column index; frame evaluation and the FSM SHALL stay in keypad_scan_ctrl.

Verification
REQ-034 Bench SHALL cover: reset, then idle for 3 frames -> columnas cycles 1000/0100/0010/0001 at 27 clocks each, key_valid stays 0.
REQ-035 Bench SHALL cover: row1 held while column2 is driven, for 4 frames, key_ready = 1 -> one key_valid pulse with key_code = 6; key_down high until 4 frames after release.
REQ-036 Bench SHALL cover: key_ready = 0 for 500 clocks after a code for row0/column0 -> key_valid and key_code = 0 held; handshake clears them the next clock.
REQ-037 Bench SHALL cover: rows 0 and 2 pressed on column1 -> MULTI, no code emitted; releasing row2 -> code 1 after 4 frames.
REQ-038 Bench SHALL cover: reset asserted in CONFIRM at frame 3 -> no code emitted; a fresh 4 frames are required afterwards.
REQ-039 Bench SHALL cover: with KEYPAD_REPEAT_EN and REPEAT_FRAMES = 8, row3/column3 held -> code 15 repeats every 8 frames; without the macro -> exactly one code.
